// File: rtl/tflaf_seq_ctrl.sv
// Sequencer for a latency-LAT adaptive filter core: run/flush control,
// token tracking of in-flight samples, output FIFO and convergence detect.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; core held, no handshakes
// S_CLR   | one cycle: core_clr high, tokens and counters cleared
// S_RUN   | samples accepted, one core enable per accepted sample
// S_FLUSH | zero-input enables until every in-flight token is pushed
module tflaf_seq_ctrl #(
   parameter int WIDTH    = 16,
   parameter int LAT      = 6,
   parameter int FDEPTH   = 4,
   parameter int CONV_LEN = 256
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   input  logic             train,
   input  logic             auto_freeze,
   input  logic [WIDTH-1:0] err_thr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] signal_in,
   input  logic [WIDTH-1:0] desired_in,
   output logic [WIDTH-1:0] core_signal,
   output logic [WIDTH-1:0] core_desired,
   output logic             core_en,
   output logic             core_clr,
   output logic             adapt_en,
   input  logic [WIDTH-1:0] core_filter_out,
   input  logic [WIDTH-1:0] core_error,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] filter_out,
   output logic [WIDTH-1:0] error_out,
   output logic             busy,
   output logic             converged
);

   localparam int CW = $clog2(FDEPTH + 1);
   localparam int PW = $clog2(FDEPTH);
   localparam int WW = $clog2(LAT + 1);
   localparam int VW = $clog2(CONV_LEN + 1);
   localparam logic [CW-1:0]    FDEPTH_C = CW'(FDEPTH);
   localparam logic [PW-1:0]    PTR_LAST = PW'(FDEPTH - 1);
   localparam logic [WW-1:0]    LAT_C    = WW'(LAT);
   localparam logic [VW-1:0]    CONV_C   = VW'(CONV_LEN);
   localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] MAX_POS  = {1'b0, {(WIDTH-1){1'b1}}};

   typedef enum logic [1:0] {S_IDLE, S_CLR, S_RUN, S_FLUSH} state_t;

   state_t           state;
   logic [LAT-1:0]   token;
   logic [WW-1:0]    warm_cnt;
   logic [VW-1:0]    conv_cnt;
   logic             conv_flag;
   logic [WIDTH-1:0] mem_f [FDEPTH];
   logic [WIDTH-1:0] mem_e [FDEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count;

   logic             token_any;
   logic             pop;
   logic             space;
   logic             accept;
   logic             flush_step;
   logic             push;
   logic [WIDTH-1:0] err_abs;
   logic             err_ok;
   logic [VW-1:0]    conv_nxt;

   // Handshake and enable decode; a full FIFO only blocks when the tail token is about to push.
   always_comb begin
      token_any  = |token;
      pop        = (count != '0) && out_ready;
      space      = (count < FDEPTH_C) || !token[LAT-1] || pop;
      accept     = (state == S_RUN) && in_valid && space;
      flush_step = (state == S_FLUSH) && token_any && space;
      push       = (accept || flush_step) && token[LAT-1];
   end

   // Saturated |error| against the threshold and the next convergence count.
   always_comb begin
      if (core_error == MIN_NEG)
         err_abs = MAX_POS;
      else if (core_error[WIDTH-1])
         err_abs = -core_error;
      else
         err_abs = core_error;
      err_ok = (err_abs <= err_thr);
      if (!err_ok)
         conv_nxt = '0;
      else if (conv_cnt == CONV_C)
         conv_nxt = conv_cnt;
      else
         conv_nxt = conv_cnt + 1'b1;
   end

   assign in_ready     = (state == S_RUN) && space;
   assign core_en      = accept || flush_step;
   assign core_signal  = accept ? signal_in : '0;
   assign core_desired = accept ? desired_in : '0;
   assign core_clr     = !reset_n || (state == S_CLR);
   assign adapt_en     = accept && train && (warm_cnt == LAT_C) && !(auto_freeze && conv_flag);
   assign busy         = (state != S_IDLE);
   assign converged    = conv_flag;
   assign out_valid    = (count != '0);
   assign filter_out   = mem_f[rd_ptr];
   assign error_out    = mem_e[rd_ptr];

   // Sequencer state, token shift register, warm-up and convergence tracking.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         token     <= '0;
         warm_cnt  <= '0;
         conv_cnt  <= '0;
         conv_flag <= 1'b0;
      end else begin
         case (state)
            S_IDLE:  if (start) state <= S_CLR;
            S_CLR:   state <= S_RUN;
            S_RUN:   if (stop) state <= S_FLUSH;
            S_FLUSH: if (!token_any) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
         if (state == S_CLR) begin
            token     <= '0;
            warm_cnt  <= '0;
            conv_cnt  <= '0;
            conv_flag <= 1'b0;
         end else begin
            if (accept || flush_step)
               token <= (token << 1) | LAT'(accept);
            if (accept && (warm_cnt != LAT_C))
               warm_cnt <= warm_cnt + 1'b1;
            if (push && train) begin
               conv_cnt <= conv_nxt;
               if (conv_nxt == CONV_C)
                  conv_flag <= 1'b1;
            end
         end
      end
   end

   // First-word fall-through result FIFO; a push into a full FIFO always coincides with a pop.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < FDEPTH; i++) begin
            mem_f[i] <= '0;
            mem_e[i] <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem_f[wr_ptr] <= core_filter_out;
            mem_e[wr_ptr] <= core_error;
            wr_ptr        <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_tflaf_seq_ctrl.sv
// Bench for tflaf_seq_ctrl: a delay-line core stand-in, a queue-based
// reference model checked every cycle, a control table and directed runs.
module tb_tflaf_seq_ctrl;

   localparam int W   = 16;
   localparam int LAT = 6;
   localparam int FD  = 4;
   localparam int CL  = 256;

   logic         clk = 1'b0;
   logic         reset_n, start, stop, train, auto_freeze;
   logic [W-1:0] err_thr;
   logic         in_valid, in_ready, out_valid, out_ready;
   logic [W-1:0] signal_in, desired_in, core_signal, core_desired;
   logic         core_en, core_clr, adapt_en, busy, converged;
   logic [W-1:0] core_filter_out, core_error, filter_out, error_out;

   tflaf_seq_ctrl #(.WIDTH(W), .LAT(LAT), .FDEPTH(FD), .CONV_LEN(CL)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stop(stop), .train(train),
      .auto_freeze(auto_freeze), .err_thr(err_thr), .in_valid(in_valid),
      .in_ready(in_ready), .signal_in(signal_in), .desired_in(desired_in),
      .core_signal(core_signal), .core_desired(core_desired), .core_en(core_en),
      .core_clr(core_clr), .adapt_en(adapt_en), .core_filter_out(core_filter_out),
      .core_error(core_error), .out_valid(out_valid), .out_ready(out_ready),
      .filter_out(filter_out), .error_out(error_out), .busy(busy),
      .converged(converged)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_pops   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Core stand-in: an LAT-deep delay line of the (signal, desired) pairs it is fed.
   logic [W-1:0] pipe_s [LAT];
   logic [W-1:0] pipe_d [LAT];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n || core_clr) begin
         for (int i = 0; i < LAT; i++) begin
            pipe_s[i] <= '0;
            pipe_d[i] <= '0;
         end
      end else if (core_en) begin
         pipe_s[0] <= core_signal;
         pipe_d[0] <= core_desired;
         for (int i = 1; i < LAT; i++) begin
            pipe_s[i] <= pipe_s[i-1];
            pipe_d[i] <= pipe_d[i-1];
         end
      end
   end
   assign core_filter_out = pipe_s[LAT-1];
   assign core_error      = pipe_d[LAT-1];

   // Reference model: in-flight samples tagged with the enable index they entered on;
   // each one leaves LAT enables later into an ordered result queue.
   typedef struct packed {int n; logic [W-1:0] s; logic [W-1:0] d;} inf_t;
   typedef struct packed {logic [W-1:0] f; logic [W-1:0] e;} res_t;
   inf_t infl[$];
   res_t expq[$];
   int   m_state = 0;  // 0 idle, 1 clear, 2 run, 3 flush
   int   en_idx = 0, acc_cnt = 0, m_cc = 0;
   bit   m_conv = 0;
   bit   pop_e, tail, sp, e_acc, e_en, e_adapt, was_empty;
   inf_t it;
   res_t rr;

   function automatic int abs_sat(input logic [W-1:0] v);
      int s;
      s = int'($signed(v));
      if (s < 0) s = -s;
      if (s > (1 << (W-1)) - 1) s = (1 << (W-1)) - 1;
      return s;
   endfunction

   always @(negedge clk) begin
      if (!reset_n) begin
         chk("rst_out_valid", out_valid, 0);
         chk("rst_in_ready", in_ready, 0);
         chk("rst_core_en", core_en, 0);
         chk("rst_adapt_en", adapt_en, 0);
         chk("rst_busy", busy, 0);
         chk("rst_converged", converged, 0);
         chk("rst_core_clr", core_clr, 1);
         chk("rst_filter_out", filter_out, 0);
         chk("rst_error_out", error_out, 0);
         chk("rst_core_signal", core_signal, 0);
         m_state = 0; en_idx = 0; acc_cnt = 0; m_cc = 0; m_conv = 0;
         infl.delete();
         expq.delete();
      end else begin
         was_empty = (infl.size() == 0);
         pop_e   = (expq.size() != 0) && out_ready;
         tail    = !was_empty && (infl[0].n + LAT == en_idx);
         sp      = (expq.size() < FD) || !tail || pop_e;
         e_acc   = (m_state == 2) && sp && in_valid;
         e_en    = e_acc || ((m_state == 3) && !was_empty && sp);
         e_adapt = e_acc && train && (acc_cnt >= LAT) && !(auto_freeze && m_conv);
         chk("in_ready", in_ready, (m_state == 2) && sp);
         chk("core_en", core_en, e_en);
         chk("adapt_en", adapt_en, e_adapt);
         chk("busy", busy, m_state != 0);
         chk("core_clr", core_clr, m_state == 1);
         chk("converged", converged, m_conv);
         chk("out_valid", out_valid, expq.size() != 0);
         chk("core_signal", core_signal, e_acc ? signal_in : 16'h0);
         chk("core_desired", core_desired, e_acc ? desired_in : 16'h0);
         if (expq.size() != 0) begin
            chk("filter_out", filter_out, expq[0].f);
            chk("error_out", error_out, expq[0].e);
         end
         if (out_valid && out_ready) n_pops++;
         if (pop_e) void'(expq.pop_front());
         if (e_en) begin
            if (tail) begin
               it = infl.pop_front();
               rr.f = it.s;
               rr.e = it.d;
               expq.push_back(rr);
               if (train) begin
                  if (abs_sat(it.d) <= int'(err_thr)) begin
                     if (m_cc < CL) m_cc++;
                  end else m_cc = 0;
                  if (m_cc == CL) m_conv = 1;
               end
            end
            if (e_acc) begin
               it.n = en_idx; it.s = signal_in; it.d = desired_in;
               infl.push_back(it);
            end
            en_idx++;
         end
         if (e_acc) acc_cnt++;
         case (m_state)
            0: if (start) m_state = 1;
            1: begin
               m_state = 2; en_idx = 0; acc_cnt = 0; m_cc = 0; m_conv = 0;
               infl.delete();
            end
            2: if (stop) m_state = 3;
            3: if (was_empty) m_state = 0;
            default: m_state = 0;
         endcase
      end
   end

   task automatic cyc();
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start = 1; cyc();
      start = 0; cyc();
   endtask

   task automatic wait_idle(input int budget);
      for (int c = 0; c < budget; c++) begin
         @(negedge clk);
         if (!busy) break;
         @(posedge clk);
         #1;
      end
      chk("idle_reached", busy, 0);
      @(posedge clk);
      #1;
   endtask

   typedef struct packed {
      logic start, stop, in_valid;
      logic e_busy, e_clr, e_rdy, e_en, e_ov;
   } vec_t;
   vec_t tbl [16];

   int base, acc, fen;

   initial begin
      // start stop in_valid | busy core_clr in_ready core_en out_valid
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

      reset_n = 0; start = 0; stop = 0; train = 0; auto_freeze = 0; err_thr = '0;
      in_valid = 0; signal_in = '0; desired_in = '0; out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1;

      // Control table: start/stop priority, start ignored in RUN, two-sample flush.
      for (int i = 0; i < 16; i++) begin
         start = tbl[i].start; stop = tbl[i].stop; in_valid = tbl[i].in_valid;
         signal_in = W'($urandom); desired_in = W'($urandom);
         @(negedge clk);
         chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
         chk($sformatf("tbl%0d_core_clr", i), core_clr, tbl[i].e_clr);
         chk($sformatf("tbl%0d_in_ready", i), in_ready, tbl[i].e_rdy);
         chk($sformatf("tbl%0d_core_en", i), core_en, tbl[i].e_en);
         chk($sformatf("tbl%0d_out_valid", i), out_valid, tbl[i].e_ov);
         @(posedge clk);
         #1;
      end
      start = 0; stop = 0; in_valid = 0;

      // Ten back-to-back samples: warm-up gating of adapt_en and first-output timing.
      train = 1; out_ready = 1; base = n_pops;
      do_start();
      for (int i = 0; i < 10; i++) begin
         in_valid = 1; signal_in = W'($urandom); desired_in = W'($urandom);
         @(negedge clk);
         chk($sformatf("bb_adapt%0d", i), adapt_en, i >= LAT);
         chk($sformatf("bb_out_valid%0d", i), out_valid, i >= LAT + 1);
         @(posedge clk);
         #1;
      end
      in_valid = 0;
      repeat (3) cyc();
      chk("bb_outputs_in_run", n_pops - base, 10 - LAT);
      stop = 1; cyc(); stop = 0;
      wait_idle(40);
      chk("bb_outputs_total", n_pops - base, 10);

      // Backpressure: stall after LAT+FDEPTH accepts, then drain in order.
      base = n_pops; acc = 0;
      do_start();
      out_ready = 0; in_valid = 1;
      for (int c = 0; c < 30; c++) begin
         signal_in = W'($urandom); desired_in = W'($urandom);
         @(negedge clk);
         if (!in_ready) break;
         acc++;
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("bp_accepts_before_stall", acc, LAT + FD);
      repeat (2) cyc();
      chk("bp_still_stalled", in_ready, 0);
      in_valid = 0; out_ready = 1;
      repeat (6) cyc();
      chk("bp_drained", n_pops - base, FD);
      stop = 1; cyc(); stop = 0;
      wait_idle(40);
      chk("bp_outputs_total", n_pops - base, LAT + FD);

      // Stop after 8 accepts: LAT zero-input flush enables with adaptation held off.
      base = n_pops; fen = 0;
      do_start();
      for (int i = 0; i < 8; i++) begin
         in_valid = 1; signal_in = W'($urandom); desired_in = W'($urandom);
         cyc();
      end
      in_valid = 0; stop = 1; cyc(); stop = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (!busy) break;
         if (core_en) begin
            fen++;
            chk("fl_adapt_off", adapt_en, 0);
         end
         @(posedge clk);
         #1;
      end
      @(posedge clk);
      #1;
      chk("fl_enables", fen, LAT);
      chk("fl_outputs_total", n_pops - base, 8);
      chk("fl_busy_low", busy, 0);

      // Convergence: sample 100 breaks the run, samples 101..356 converge.
      err_thr = 16'h0010; auto_freeze = 1; train = 1;
      do_start();
      for (int a = 1; a <= 370; a++) begin
         in_valid = 1; signal_in = W'($urandom);
         desired_in = (a == 100) ? 16'h0020 : ((a % 2) != 0 ? 16'h0008 : 16'hFFF8);
         @(negedge clk);
         if (a == 263) chk("cv_restarted", converged, 0);
         if (a == 362) begin
            chk("cv_before", converged, 0);
            chk("cv_adapt_before", adapt_en, 1);
         end
         if (a == 363) begin
            chk("cv_after", converged, 1);
            chk("cv_frozen", adapt_en, 0);
         end
         @(posedge clk);
         #1;
      end
      in_valid = 0; stop = 1; cyc(); stop = 0;
      wait_idle(40);
      chk("cv_sticky_idle", converged, 1);
      do_start();
      @(negedge clk);
      chk("cv_cleared_by_clr", converged, 0);
      @(posedge clk);
      #1;
      stop = 1; cyc(); stop = 0;
      wait_idle(20);
      auto_freeze = 0;

      // Reset mid-run with three results buffered.
      do_start();
      out_ready = 0;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1; signal_in = W'($urandom); desired_in = W'($urandom);
         cyc();
      end
      in_valid = 0; cyc();
      chk("rr_buffered", out_valid, 1);
      chk("rr_ready_before", in_ready, 1);
      reset_n = 0;
      #1;
      chk("rr_out_valid_now", out_valid, 0);
      chk("rr_in_ready_now", in_ready, 0);
      chk("rr_core_clr_now", core_clr, 1);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset_n = 1; in_valid = 1; out_ready = 1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("rr_idle_busy", busy, 0);
         chk("rr_idle_out_valid", out_valid, 0);
         chk("rr_idle_in_ready", in_ready, 0);
         @(posedge clk);
         #1;
      end
      in_valid = 0;

      // Randomised traffic against the reference model.
      for (int c = 0; c < 3000; c++) begin
         start    = ($urandom % 40) == 0;
         stop     = ($urandom % 60) == 0;
         in_valid = ($urandom % 10) < 7;
         out_ready = ($urandom % 10) < 6;
         if (($urandom % 50) == 0) train = ~train;
         if (($urandom % 200) == 0) auto_freeze = ~auto_freeze;
         if (($urandom % 100) == 0) err_thr = ($urandom % 2) != 0 ? 16'h7FFF : W'($urandom % 64);
         signal_in = W'($urandom);
         case ($urandom % 4)
            0: desired_in = W'($urandom);
            1: desired_in = 16'h8000;
            2: desired_in = W'($urandom % 32);
            default: desired_in = 16'h0 - W'($urandom % 32);
         endcase
         cyc();
      end
      start = 0; in_valid = 0; out_ready = 1;
      stop = 1; cyc(); stop = 0;
      wait_idle(60);
      repeat (6) cyc();
      chk("rnd_scoreboard_empty", expq.size(), 0);
      chk("rnd_out_valid_empty", out_valid, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
